cond_unit_pipe: RTL and testbench

- Pipelined successor to the single-cycle conditional logic, for the pipelined ARM core.
- Holds a decode-to-execute (D->E) control register, the NZCV flag register and full ARM condition evaluation.
- Gates the execute-stage write, branch and PC-source controls by the evaluated condition.
- Supports stall, flush, a configurable flag reset value and optional performance counters.

---
 rtl/cond_unit_pipe.sv | 131 +++++++++++++
 tb/tb_cond_unit_pipe.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit_pipe.sv
// Pipelined ARM conditional unit: D->E control register, NZCV flags and gated execute controls.
// Optional performance counters are enabled by defining COND_PERF_EN.
module cond_unit_pipe #(
  parameter logic [3:0] RST_FLAGS = 4'b0000,
  parameter int         CNT_W     = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       CondD,
  input  logic [1:0]       FlagWD,
  input  logic             PCSD,
  input  logic             RegWD,
  input  logic             MemWD,
  input  logic             BranchD,
  input  logic [3:0]       ALUFlags,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchTakenE,
  output logic             CondExE,
  output logic             ValidE,
`ifdef COND_PERF_EN
  output logic [CNT_W-1:0] CntExec,
  output logic [CNT_W-1:0] CntSquash,
`endif
  output logic [3:0]       Flags
);

  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("cond_unit_pipe: CNT_W must be at least 1");
  end

  logic [3:0] cond_e;
  logic [1:0] flagw_e;
  logic       pcs_e;
  logic       regw_e;
  logic       memw_e;
  logic       branch_e;
  logic       cond_ex;
  logic       adv;
  logic       n_f, z_f, c_f, v_f;

  assign adv = !StallE | FlushE;
  assign {n_f, z_f, c_f, v_f} = Flags;

  always_comb begin
    cond_ex = 1'b0;
    case (cond_e)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = !z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = !c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = !n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = !v_f;
      4'b1000: cond_ex = c_f & !z_f;
      4'b1001: cond_ex = !c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = !z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  assign CondExE      = ValidE & cond_ex;
  assign PCSrcE       = pcs_e & CondExE;
  assign RegWriteE    = regw_e & CondExE;
  assign MemWriteE    = memw_e & CondExE;
  assign BranchTakenE = branch_e & CondExE;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ValidE   <= 1'b0;
      cond_e   <= 4'b0000;
      flagw_e  <= 2'b00;
      pcs_e    <= 1'b0;
      regw_e   <= 1'b0;
      memw_e   <= 1'b0;
      branch_e <= 1'b0;
    end else if (adv) begin
      if (FlushE) begin
        ValidE   <= 1'b0;
        cond_e   <= 4'b0000;
        flagw_e  <= 2'b00;
        pcs_e    <= 1'b0;
        regw_e   <= 1'b0;
        memw_e   <= 1'b0;
        branch_e <= 1'b0;
      end else begin
        ValidE   <= 1'b1;
        cond_e   <= CondD;
        flagw_e  <= FlagWD;
        pcs_e    <= PCSD;
        regw_e   <= RegWD;
        memw_e   <= MemWD;
        branch_e <= BranchD;
      end
    end
  end

  // Flags commit only as the E instruction leaves, so a held instruction sees stable flags.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Flags <= RST_FLAGS;
    end else if (adv && CondExE) begin
      if (flagw_e[1]) Flags[3:2] <= ALUFlags[3:2];
      if (flagw_e[0]) Flags[1:0] <= ALUFlags[1:0];
    end
  end

`ifdef COND_PERF_EN
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      CntExec   <= '0;
      CntSquash <= '0;
    end else if (adv && ValidE) begin
      if (CondExE) begin
        if (CntExec != {CNT_W{1'b1}}) CntExec <= CntExec + 1'b1;
      end else begin
        if (CntSquash != {CNT_W{1'b1}}) CntSquash <= CntSquash + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Self-checking bench for cond_unit_pipe: directed scenarios plus randomized traffic against a reference model.
module tb_cond_unit_pipe;
  localparam int         CNT_W     = 2;
  localparam logic [3:0] RST_FLAGS = 4'b0000;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic       StallE = 1'b0, FlushE = 1'b0;
  logic [3:0] CondD = 4'h0, ALUFlags = 4'h0;
  logic [1:0] FlagWD = 2'b00;
  logic       PCSD = 1'b0, RegWD = 1'b0, MemWD = 1'b0, BranchD = 1'b0;
  logic       PCSrcE, RegWriteE, MemWriteE, BranchTakenE, CondExE, ValidE;
  logic [3:0] Flags;
`ifdef COND_PERF_EN
  logic [CNT_W-1:0] CntExec, CntSquash;
`endif

  cond_unit_pipe #(.RST_FLAGS(RST_FLAGS), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .StallE(StallE), .FlushE(FlushE),
    .CondD(CondD), .FlagWD(FlagWD), .PCSD(PCSD), .RegWD(RegWD),
    .MemWD(MemWD), .BranchD(BranchD), .ALUFlags(ALUFlags),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchTakenE(BranchTakenE), .CondExE(CondExE), .ValidE(ValidE),
`ifdef COND_PERF_EN
    .CntExec(CntExec), .CntSquash(CntSquash),
`endif
    .Flags(Flags)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the instruction sitting in E, committed flags and event counts.
  bit         m_valid;
  logic [3:0] m_cond;
  logic [1:0] m_fw;
  bit         m_pcs, m_regw, m_memw, m_br;
  logic [3:0] m_flags;
  int         m_exec, m_sq;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic bit cond_pass(input logic [3:0] cond, input logic [3:0] f);
    bit n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_cond = 4'h0; m_fw = 2'b00;
    m_pcs = 0; m_regw = 0; m_memw = 0; m_br = 0;
    m_flags = RST_FLAGS; m_exec = 0; m_sq = 0;
  endtask

  task automatic model_edge();
    bit passes;
    passes = m_valid && cond_pass(m_cond, m_flags);
    if (StallE && !FlushE) return;
    if (m_valid) begin
      if (passes) m_exec = (m_exec < CNT_MAX) ? m_exec + 1 : CNT_MAX;
      else        m_sq   = (m_sq   < CNT_MAX) ? m_sq + 1   : CNT_MAX;
    end
    if (passes && m_fw[1]) m_flags[3:2] = ALUFlags[3:2];
    if (passes && m_fw[0]) m_flags[1:0] = ALUFlags[1:0];
    if (FlushE) begin
      m_valid = 0; m_cond = 4'h0; m_fw = 2'b00;
      m_pcs = 0; m_regw = 0; m_memw = 0; m_br = 0;
    end else begin
      m_valid = 1; m_cond = CondD; m_fw = FlagWD;
      m_pcs = PCSD; m_regw = RegWD; m_memw = MemWD; m_br = BranchD;
    end
  endtask

  task automatic compare_all(input string tag);
    bit cx;
    cx = m_valid && cond_pass(m_cond, m_flags);
    chk({tag, ".valid"},  32'(ValidE),       32'(m_valid));
    chk({tag, ".condex"}, 32'(CondExE),      32'(cx));
    chk({tag, ".flags"},  32'(Flags),        32'(m_flags));
    chk({tag, ".pcsrc"},  32'(PCSrcE),       32'(m_pcs && cx));
    chk({tag, ".regw"},   32'(RegWriteE),    32'(m_regw && cx));
    chk({tag, ".memw"},   32'(MemWriteE),    32'(m_memw && cx));
    chk({tag, ".branch"}, 32'(BranchTakenE), 32'(m_br && cx));
`ifdef COND_PERF_EN
    chk({tag, ".cntexec"}, 32'(CntExec),   32'(m_exec));
    chk({tag, ".cntsq"},   32'(CntSquash), 32'(m_sq));
`endif
  endtask

  task automatic drive(input logic [3:0] cond, input logic [1:0] fw, input logic pcs,
                       input logic regw, input logic memw, input logic br, input logic [3:0] alu);
    CondD = cond; FlagWD = fw; PCSD = pcs; RegWD = regw; MemWD = memw; BranchD = br; ALUFlags = alu;
  endtask

  task automatic cycle(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Asynchronous reset asserted mid-cycle, checked before any clock edge, released before the next edge.
  task automatic async_reset(input string tag);
    @(posedge Clk);
    model_edge();
    #3;
    Rst = 1'b0;
    model_reset();
    #1;
    compare_all(tag);
    chk({tag, ".valid0"}, 32'(ValidE), 32'(0));
    chk({tag, ".regw0"},  32'(RegWriteE), 32'(0));
    #1;
    Rst = 1'b1;
  endtask

  logic [3:0] held_flags;

  initial begin
    model_reset();
    #1 Rst = 1'b0;
    #2 compare_all("reset");
    chk("reset.flags_const", 32'(Flags), 32'(4'b0000));
    #10 Rst = 1'b1;

    // CMP then BEQ, taken
    drive(4'hE, 2'b11, 0, 0, 0, 0, 4'h0);  cycle("cmp_in");
    drive(4'h0, 2'b00, 1, 0, 0, 1, 4'b0100); cycle("beq");
    chk("beq.flags",  32'(Flags), 32'(4'b0100));
    chk("beq.taken",  32'(BranchTakenE), 32'(1));
    chk("beq.pcsrc",  32'(PCSrcE), 32'(1));
    // CMP then BEQ, not taken
    drive(4'hE, 2'b11, 0, 0, 0, 0, 4'hF);  cycle("cmp_in2");
    drive(4'h0, 2'b00, 1, 0, 0, 1, 4'b0000); cycle("beq2");
    chk("beq2.flags", 32'(Flags), 32'(4'b0000));
    chk("beq2.taken", 32'(BranchTakenE), 32'(0));

    // Stall: flag-setting AL held for three cycles while ALUFlags toggles
    drive(4'hE, 2'b11, 0, 1, 0, 0, 4'h0); cycle("stall_in");
    held_flags = Flags;
    drive(4'h1, 2'b00, 1, 1, 1, 1, 4'h0);
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALUFlags = (i % 2 == 0) ? 4'b1111 : 4'b0101;
      cycle("stall_hold");
      chk("stall.flags_held", 32'(Flags), 32'(held_flags));
      chk("stall.regw_held",  32'(RegWriteE), 32'(1));
    end
    StallE = 1'b0; ALUFlags = 4'b1010;
    cycle("stall_release");
    chk("stall.flags_release", 32'(Flags), 32'(4'b1010));

    // Flush has priority over stall; departing flag write still commits
    drive(4'hE, 2'b11, 0, 1, 0, 0, 4'h0); cycle("flush_in");
    drive(4'hE, 2'b00, 0, 1, 0, 0, 4'b0011);
    StallE = 1'b1; FlushE = 1'b1;
    cycle("flush_stall");
    chk("flush.valid", 32'(ValidE), 32'(0));
    chk("flush.regw",  32'(RegWriteE), 32'(0));
    chk("flush.flags", 32'(Flags), 32'(4'b0011));
    StallE = 1'b0; FlushE = 1'b0;

    // Condition sweep: all 16 conditions against all 16 flag values
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < 16; c++) begin
        drive(4'hE, 2'b11, 0, 0, 0, 0, 4'h0); cycle("sw_set");
        drive(4'(c), 2'b00, 0, 1, 0, 0, 4'(f)); cycle("sw_eval");
        chk($sformatf("sw.c%0d.f%0d", c, f), 32'(CondExE), 32'(cond_pass(4'(c), 4'(f))));
        if (c == 15) chk($sformatf("sw.nv.f%0d", f), 32'(RegWriteE), 32'(0));
      end
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 4'($urandom));
      StallE = ($urandom_range(0, 4) == 0);
      FlushE = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end
    StallE = 1'b0; FlushE = 1'b0;

    // Mid-run reset with a valid instruction in E
    drive(4'hE, 2'b11, 1, 1, 1, 1, 4'hF); cycle("rst_fill");
    chk("rst_fill.valid", 32'(ValidE), 32'(1));
    async_reset("rst_mid");
    chk("rst_mid.flags", 32'(Flags), 32'(4'b0000));
    chk("rst_mid.pcsrc", 32'(PCSrcE), 32'(0));
    chk("rst_mid.branch", 32'(BranchTakenE), 32'(0));
    chk("rst_mid.memw", 32'(MemWriteE), 32'(0));

`ifdef COND_PERF_EN
    // 3 executed, 2 squashed, 1 bubble, 2 stalls, 2 more executed
    drive(4'hE, 2'b00, 0, 1, 0, 0, 4'h0); cycle("perf_a0");
    cycle("perf_a1");
    cycle("perf_a2");
    drive(4'hF, 2'b00, 0, 1, 0, 0, 4'h0); cycle("perf_nv0");
    cycle("perf_nv1");
    drive(4'hE, 2'b00, 0, 1, 0, 0, 4'h0);
    FlushE = 1'b1; cycle("perf_bubble");
    FlushE = 1'b0; cycle("perf_b_out");
    StallE = 1'b1; cycle("perf_st0");
    cycle("perf_st1");
    StallE = 1'b0; cycle("perf_x0");
    cycle("perf_x1");
    chk("perf.exec_sat", 32'(CntExec), 32'(3));
    chk("perf.squash",   32'(CntSquash), 32'(2));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
